// File: rtl/onchip_mem_test_pkg.sv
// Shared definitions for the on-chip memory test master.
// Holds the FSM state encoding, the default address/data widths and the
// error counter width used by the top and the checker.
package onchip_mem_test_pkg;

   localparam int unsigned DEF_ADDR_W = 14;
   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned ERR_W      = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR      = 3'd1,
      RD_REQ  = 3'd2,
      RD_WAIT = 3'd3,
      FIN     = 3'd4
   } state_t;

endpackage

// File: rtl/onchip_mem_test_master_if.sv
// Avalon-MM master bus bundle used by the memory test master.
// master modport: drives address/byteenable/read/write/writedata,
//                 receives waitrequest/readdata/readdatavalid.
// slave modport : the mirror image, for a memory or bus model.
interface onchip_mem_test_master_if #(
   parameter int unsigned ADDR_W = onchip_mem_test_pkg::DEF_ADDR_W,
   parameter int unsigned DATA_W = onchip_mem_test_pkg::DEF_DATA_W
) ();

   logic [ADDR_W-1:0]   avm_address;
   logic [DATA_W/8-1:0] avm_byteenable;
   logic                avm_read;
   logic                avm_write;
   logic [DATA_W-1:0]   avm_writedata;
   logic                avm_waitrequest;
   logic [DATA_W-1:0]   avm_readdata;
   logic                avm_readdatavalid;

   modport master (
      output avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
      input  avm_waitrequest, avm_readdata, avm_readdatavalid
   );

   modport slave (
      input  avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
      output avm_waitrequest, avm_readdata, avm_readdatavalid
   );

endinterface

// File: rtl/onchip_mem_test_chk.sv
// Read-back checker for the memory test master.
// Compares returned read data with the expected pattern word, counts
// mismatches (saturating) and records the address of the first one.
// Ports: clk, reset (sync, active high), clear (new test), check_en (a read
//        word is present), rdata/exp_data/addr (the word under test),
//        err_count / first_err_addr (registered results).
module onchip_mem_test_chk
   import onchip_mem_test_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              check_en,
   input  logic [DATA_W-1:0] rdata,
   input  logic [DATA_W-1:0] exp_data,
   input  logic [ADDR_W-1:0] addr,
   output logic [ERR_W-1:0]  err_count,
   output logic [ADDR_W-1:0] first_err_addr
);

   logic mismatch_c;

   assign mismatch_c = check_en && (rdata != exp_data);

   // Error count saturates; first address is taken only while the count is still zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_count      <= '0;
         first_err_addr <= '0;
      end else if (clear) begin
         err_count      <= '0;
         first_err_addr <= '0;
      end else if (mismatch_c) begin
         if (err_count == '0) begin
            first_err_addr <= addr;
         end
         if (err_count != '1) begin
            err_count <= err_count + ERR_W'(1);
         end
      end
   end

endmodule

// File: rtl/onchip_mem_test_master.sv
// On-chip memory test master.
// On start, writes an incrementing pattern (seed + i) to word_count words
// starting at base_addr, then reads each word back one at a time and checks
// it, reporting pass / err_count / first_err_addr with a one-cycle done.
// Ports: clk, reset (sync, active high), start, base_addr, word_count, seed,
//        avm (Avalon-MM master bundle), busy, done, pass, err_count,
//        first_err_addr.
module onchip_mem_test_master
   import onchip_mem_test_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [ADDR_W-1:0]        base_addr,
   input  logic [ADDR_W:0]          word_count,
   input  logic [DATA_W-1:0]        seed,
   onchip_mem_test_master_if.master avm,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [ERR_W-1:0]         err_count,
   output logic [ADDR_W-1:0]        first_err_addr
);

   localparam int unsigned CNT_W = ADDR_W + 1;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] seed_q, seed_d;
   logic [DATA_W-1:0] exp_q, exp_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  remain_q, remain_d;
   logic              read_q, read_d;
   logic              write_q, write_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;

   logic              accept_c;
   logic              last_c;
   logic              clear_c;
   logic              check_c;

   assign accept_c = (read_q || write_q) && !avm.avm_waitrequest;
   assign last_c   = (remain_q == CNT_W'(1));

   assign avm.avm_address    = addr_q;
   assign avm.avm_byteenable = '1;
   assign avm.avm_read       = read_q;
   assign avm.avm_write      = write_q;
   assign avm.avm_writedata  = wdata_q;

   assign busy = busy_q;
   assign done = done_q;
   assign pass = pass_q;

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         base_q   <= '0;
         wdata_q  <= '0;
         seed_q   <= '0;
         exp_q    <= '0;
         cnt_q    <= '0;
         remain_q <= '0;
         read_q   <= 1'b0;
         write_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         base_q   <= base_d;
         wdata_q  <= wdata_d;
         seed_q   <= seed_d;
         exp_q    <= exp_d;
         cnt_q    <= cnt_d;
         remain_q <= remain_d;
         read_q   <= read_d;
         write_q  <= write_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
      end
   end

   // Next state and next register values; everything holds unless a
   // command is accepted, so stalled commands stay stable.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      base_d   = base_q;
      wdata_d  = wdata_q;
      seed_d   = seed_q;
      exp_d    = exp_q;
      cnt_d    = cnt_q;
      remain_d = remain_q;
      read_d   = read_q;
      write_d  = write_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      pass_d   = pass_q;
      clear_c  = 1'b0;
      check_c  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               clear_c  = 1'b1;
               base_d   = base_addr;
               cnt_d    = word_count;
               seed_d   = seed;
               remain_d = word_count;
               addr_d   = base_addr;
               wdata_d  = seed;
               pass_d   = 1'b0;
               busy_d   = 1'b1;
               if (word_count == '0) begin
                  state_d = FIN;
               end else begin
                  state_d = WR;
                  write_d = 1'b1;
               end
            end
         end

         WR: begin
            if (accept_c) begin
               if (last_c) begin
                  // Write phase complete: rewind to the first word for read-back.
                  state_d  = RD_REQ;
                  write_d  = 1'b0;
                  read_d   = 1'b1;
                  addr_d   = base_q;
                  exp_d    = seed_q;
                  remain_d = cnt_q;
               end else begin
                  remain_d = remain_q - CNT_W'(1);
                  addr_d   = addr_q + ADDR_W'(1);
                  wdata_d  = wdata_q + DATA_W'(1);
               end
            end
         end

         RD_REQ: begin
            if (accept_c) begin
               state_d = RD_WAIT;
               read_d  = 1'b0;
            end
         end

         RD_WAIT: begin
            if (avm.avm_readdatavalid) begin
               check_c = 1'b1;
               if (last_c) begin
                  state_d = FIN;
               end else begin
                  state_d  = RD_REQ;
                  read_d   = 1'b1;
                  remain_d = remain_q - CNT_W'(1);
                  addr_d   = addr_q + ADDR_W'(1);
                  exp_d    = exp_q + DATA_W'(1);
               end
            end
         end

         FIN: begin
            // err_count already includes the final compare here.
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_count == '0);
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   onchip_mem_test_chk #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_chk (
      .clk            (clk),
      .reset          (reset),
      .clear          (clear_c),
      .check_en       (check_c),
      .rdata          (avm.avm_readdata),
      .exp_data       (exp_q),
      .addr           (addr_q),
      .err_count      (err_count),
      .first_err_addr (first_err_addr)
   );

endmodule

// File: tb/tb_onchip_mem_test_master.sv
// Scoreboard bench for onchip_mem_test_master: a slave/memory model with
// optional stalls, read latency, a stuck bit and stray readdatavalid pulses;
// expected bus traffic and results come from a plain reference model.
module tb_onchip_mem_test_master;

   localparam int unsigned AW = 14;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = AW + 1;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   typedef struct packed {
      logic          pass;
      logic [15:0]   errs;
      logic [AW-1:0] first;
   } res_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [CW-1:0] word_count;
   logic [DW-1:0] seed;
   logic          busy, done, pass;
   logic [15:0]   err_count;
   logic [AW-1:0] first_err_addr;

   onchip_mem_test_master_if #(.ADDR_W(AW), .DATA_W(DW)) avm ();

   onchip_mem_test_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .base_addr      (base_addr),
      .word_count     (word_count),
      .seed           (seed),
      .avm            (avm),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_count      (err_count),
      .first_err_addr (first_err_addr)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   wr_t           wr_q[$];
   logic [AW-1:0] rd_q[$];
   res_t          res_q[$];
   res_t          last_res;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   bit            wait_en  = 1'b0;
   bit            stuck_en = 1'b0;
   bit            spur_en  = 1'b0;
   int            lat_max  = 1;
   int            rd_acc   = 0;
   int            strobes  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Slave + monitor: decides stalls, returns read data, checks every
   // accepted command and every done pulse against the scoreboard queues.
   int            pend = 0;
   logic [AW-1:0] pend_addr;
   bit            prev_stall = 1'b0;
   logic [47:0]   prev_cmd;
   wr_t           ew;
   res_t          er;
   logic [AW-1:0] ea;

   always @(negedge clk) begin
      if (reset) begin
         pend                  = 0;
         prev_stall            = 1'b0;
         avm.avm_waitrequest   = 1'b0;
         avm.avm_readdatavalid = 1'b0;
         avm.avm_readdata      = '0;
      end else begin
         if (prev_stall)
            chk("stall_hold", 64'(prev_cmd),
                64'({avm.avm_read, avm.avm_write, avm.avm_address, avm.avm_writedata}));
         if (avm.avm_read || avm.avm_write) begin
            strobes++;
            chk("rw_overlap", 64'(avm.avm_read && avm.avm_write), 64'(0));
            chk("byteenable", 64'(avm.avm_byteenable), 64'(4'hF));
         end
         if (avm.avm_read)
            chk("one_outstanding", 64'(pend), 64'(0));

         avm.avm_readdatavalid = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               avm.avm_readdatavalid = 1'b1;
               avm.avm_readdata      = mem[pend_addr];
            end
         end else if (spur_en && avm.avm_write && ($urandom_range(0, 3) == 0)) begin
            avm.avm_readdatavalid = 1'b1;
            avm.avm_readdata      = $urandom;
         end

         avm.avm_waitrequest = wait_en ? 1'($urandom_range(0, 1)) : 1'b0;

         if (avm.avm_write && !avm.avm_waitrequest) begin
            if (wr_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_write: addr 0x%0h, expected no write", avm.avm_address);
            end else begin
               ew = wr_q.pop_front();
               chk("wr_addr", 64'(avm.avm_address), 64'(ew.addr));
               chk("wr_data", 64'(avm.avm_writedata), 64'(ew.data));
            end
            mem[avm.avm_address] = (stuck_en && avm.avm_address == AW'(2)) ?
                                   (avm.avm_writedata & ~DW'(1)) : avm.avm_writedata;
         end
         if (avm.avm_read && !avm.avm_waitrequest) begin
            rd_acc++;
            if (rd_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_read: addr 0x%0h, expected no read", avm.avm_address);
            end else begin
               ea = rd_q.pop_front();
               chk("rd_addr", 64'(avm.avm_address), 64'(ea));
            end
            pend      = $urandom_range(1, lat_max);
            pend_addr = avm.avm_address;
         end
         prev_stall = (avm.avm_read || avm.avm_write) && avm.avm_waitrequest;
         prev_cmd   = {avm.avm_read, avm.avm_write, avm.avm_address, avm.avm_writedata};

         if (done) begin
            if (res_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL spurious_done: done=1, expected 0");
            end else begin
               er = res_q.pop_front();
               chk("res_pass", 64'(pass), 64'(er.pass));
               chk("res_errs", 64'(err_count), 64'(er.errs));
               chk("res_first", 64'(first_err_addr), 64'(er.first));
               chk("res_busy", 64'(busy), 64'(0));
            end
         end
      end
   end

   // Reference model + start pulse; checks the t+1 (and t+2 for empty) behaviour.
   task automatic launch(input logic [AW-1:0] b, input int c, input logic [DW-1:0] s, input bit poke);
      int            errs = 0;
      logic [AW-1:0] first = '0;
      logic [AW-1:0] a;
      logic [DW-1:0] d, st;
      for (int i = 0; i < c; i++) begin
         a  = AW'((32'(b) + 32'(i)) % 32'(1 << AW));
         d  = s + DW'(i);
         wr_q.push_back('{addr: a, data: d});
         rd_q.push_back(a);
         st = (stuck_en && a == AW'(2)) ? (d & ~DW'(1)) : d;
         if (st != d) begin
            if (errs == 0) first = a;
            if (errs < 65535) errs++;
         end
      end
      last_res = '{pass: (errs == 0), errs: 16'(errs), first: first};
      res_q.push_back(last_res);

      @(negedge clk);
      base_addr = b; word_count = CW'(c); seed = s; start = 1'b1;
      @(negedge clk);
      start = poke;
      base_addr = AW'($urandom); word_count = CW'($urandom); seed = $urandom;
      chk("busy_t1", 64'(busy), 64'(1));
      chk("write_t1", 64'(avm.avm_write), 64'(c != 0));
      @(negedge clk);
      start = 1'b0;
      if (c == 0) chk("done_t2", 64'(done), 64'(1));
   endtask

   task automatic finish_wait();
      int k = 0;
      while (res_q.size() != 0 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      if (res_q.size() != 0) begin
         n_tests++; n_fail++;
         $display("FAIL timeout: done not seen within %0d cycles", k);
         wr_q.delete(); rd_q.delete(); res_q.delete();
      end
      chk("wr_q_drained", 64'(wr_q.size()), 64'(0));
      chk("rd_q_drained", 64'(rd_q.size()), 64'(0));
      repeat (2) @(negedge clk);
      chk("hold_pass", 64'(pass), 64'(last_res.pass));
      chk("hold_errs", 64'(err_count), 64'(last_res.errs));
      chk("hold_first", 64'(first_err_addr), 64'(last_res.first));
      chk("hold_done_low", 64'(done), 64'(0));
   endtask

   task automatic run(input logic [AW-1:0] b, input int c, input logic [DW-1:0] s, input bit poke);
      launch(b, c, s, poke);
      finish_wait();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_read"}, 64'(avm.avm_read), 64'(0));
      chk({tag, "_write"}, 64'(avm.avm_write), 64'(0));
      chk({tag, "_addr"}, 64'(avm.avm_address), 64'(0));
      chk({tag, "_wdata"}, 64'(avm.avm_writedata), 64'(0));
      chk({tag, "_busy"}, 64'(busy), 64'(0));
      chk({tag, "_done"}, 64'(done), 64'(0));
      chk({tag, "_pass"}, 64'(pass), 64'(0));
      chk({tag, "_errs"}, 64'(err_count), 64'(0));
      chk({tag, "_first"}, 64'(first_err_addr), 64'(0));
      chk({tag, "_be"}, 64'(avm.avm_byteenable), 64'(4'hF));
   endtask

   initial begin
      int  s0;
      bit  hit;
      reset = 1'b1; start = 1'b0;
      base_addr = '0; word_count = '0; seed = '0;
      repeat (3) @(posedge clk);
      #1 chk_all_zero("rst");
      @(negedge clk);
      reset = 1'b0;

      // Zero-wait slave, fixed pattern.
      lat_max = 1;
      run(AW'(0), 4, 32'h1000_0000, 1'b0);

      // Stuck bit 0 at address 2.
      stuck_en = 1'b1;
      run(AW'(0), 4, 32'h0000_0001, 1'b0);
      run(AW'(0), 8, 32'h0000_0001, 1'b0);
      stuck_en = 1'b0;

      // Random stalls and late read data.
      wait_en = 1'b1; lat_max = 3;
      for (int t = 0; t < 3; t++)
         run(AW'($urandom), 16, $urandom, 1'b0);

      // Address wrap at the top of the space.
      run(AW'(14'h3FFE), 4, $urandom, 1'b0);

      // Empty test: no bus strobes at all.
      s0 = strobes;
      run(AW'($urandom), 0, $urandom, 1'b1);
      chk("empty_no_strobes", 64'(strobes - s0), 64'(0));

      // Stray start and stray readdatavalid during a test are ignored.
      spur_en = 1'b1;
      for (int t = 0; t < 3; t++)
         run(AW'($urandom), $urandom_range(1, 12), $urandom, 1'b1);
      spur_en = 1'b0;

      // Reset while waiting for read data.
      s0  = rd_acc;
      hit = 1'b0;
      launch(AW'(14'h0100), 8, 32'hCAFE_0000, 1'b0);
      for (int k = 0; k < 1000; k++) begin
         if (rd_acc >= s0 + 2 && !avm.avm_read && busy) begin
            hit = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("reached_rd_wait", 64'(hit), 64'(1));
      reset = 1'b1;
      @(posedge clk);
      #1 chk_all_zero("abort");
      @(negedge clk);
      reset = 1'b0;
      wr_q.delete(); rd_q.delete(); res_q.delete();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("abort_no_done", 64'(done), 64'(0));
      end
      run(AW'(14'h0200), 6, 32'h0BAD_F00D, 1'b0);

      // A few unconstrained runs.
      for (int t = 0; t < 3; t++)
         run(AW'($urandom), $urandom_range(0, 20), $urandom, 1'($urandom_range(0, 1)));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
